// File: rtl/mac_pkg.sv
// Shared types and constants for the 6x6 multiply-accumulate slice.
// Holds the FSM state encoding and the helper that sizes the product counters.
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } mac_state_e;

  localparam int OP_W   = 6;
  localparam int PROD_W = 12;

  // Smallest bit count able to index 'value' distinct states
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/mac_product_stage.sv
// Stage 1 of the MAC: structural 6x6 unsigned array multiplier feeding a product
// register with a valid flag, both cleared synchronously on rst or clr.
module mac_product_stage
  import mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p_reg,
  output logic              p_vld
);

  logic [OP_W:0][PROD_W-1:0] row;

  assign row[0] = '0;

  // Each array row adds the shifted partial product a*b[i] to the running total
  for (genvar i = 0; i < OP_W; i++) begin : g_row
    logic [PROD_W-1:0] pp;
    assign pp         = b[i] ? (PROD_W'(a) << i) : '0;
    assign row[i + 1] = row[i] + pp;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      p_reg <= '0;
      p_vld <= 1'b0;
    end else begin
      p_vld <= load;
      if (load) p_reg <= row[OP_W];
    end
  end

endmodule

// File: rtl/mac_accumulator_6bit.sv
// Multiply-accumulate stage: registers LEN products, sums them modulo 2^ACC_W
// with a sticky carry flag, and holds the total until the consumer takes it.
module mac_accumulator_6bit
  import mac_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  localparam int                CNT_W  = clog2(LEN + 1);
  localparam logic [CNT_W-1:0]  LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(LEN - 1);

  mac_state_e        state;
  mac_state_e        state_next;
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  added_cnt;
  logic [ACC_W-1:0]  acc;
  logic [PROD_W-1:0] p_reg;
  logic              p_vld;
  logic              accept;
  logic              last_add;
  logic              result_taken;
  logic [ACC_W:0]    sum;

  assign accept       = in_valid && in_ready;
  assign last_add     = p_vld && (added_cnt == LAST_C);
  assign result_taken = out_valid && out_ready;
  assign sum          = {1'b0, acc} + (ACC_W + 1)'(p_reg);
  assign acc_out      = acc;

  mac_product_stage u_product (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load  (accept),
    .a     (a),
    .b     (b),
    .p_reg (p_reg),
    .p_vld (p_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (last_add)     state_next = DONE;
        DONE:    if (result_taken) state_next = ACCUM;
        default: state_next = ACCUM;
      endcase
    end
  end

  // in_ready is masked by rst and clr so an operand is never offered while it would be dropped
  always_comb begin
    out_valid = (state == DONE);
    in_ready  = !rst && !clr && (state == ACCUM) && (taken_cnt < LEN_C);
  end

  always_ff @(posedge clk) begin
    if (rst || clr || result_taken) begin
      acc       <= '0;
      ovf       <= 1'b0;
      taken_cnt <= '0;
      added_cnt <= '0;
    end else begin
      if (accept) taken_cnt <= taken_cnt + 1'b1;
      if (p_vld) begin
        acc       <= sum[ACC_W-1:0];
        ovf       <= ovf | sum[ACC_W];
        added_cnt <= added_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator_6bit.sv
// Self-checking bench for mac_accumulator_6bit: directed scenarios plus random traffic,
// all compared against a transaction-level model of accepted products and their sum.
module tb_mac_accumulator_6bit;

  localparam int LEN     = 4;
  localparam int ACC_W   = 16;
  localparam int S_LEN   = 2;
  localparam int S_ACC_W = 12;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       a;
  logic [5:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;

  logic               s_in_valid;
  logic               s_in_ready;
  logic [5:0]         s_a;
  logic [5:0]         s_b;
  logic               s_out_valid;
  logic               s_out_ready;
  logic [S_ACC_W-1:0] s_acc_out;
  logic               s_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dut_accepts = 0;
  bit last_accepted;

  int m_sum;
  int m_taken;
  int m_added;
  int m_prod;
  bit m_pend;
  bit m_done;

  mac_accumulator_6bit #(.LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .ovf       (ovf)
  );

  mac_accumulator_6bit #(.LEN(S_LEN), .ACC_W(S_ACC_W)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .a         (s_a),
    .b         (s_b),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .acc_out   (s_acc_out),
    .ovf       (s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    m_sum   = 0;
    m_taken = 0;
    m_added = 0;
    m_prod  = 0;
    m_pend  = 1'b0;
    m_done  = 1'b0;
  endtask

  // One clock cycle: drive, check outputs against the model, clock, advance the model
  task automatic applyStimulus(input bit r, input bit c, input bit iv,
                               input logic [5:0] ia, input logic [5:0] ib, input bit ordy);
    bit exp_rdy;
    bit acc_now;
    bit done_before;
    rst = r; clr = c; in_valid = iv; a = ia; b = ib; out_ready = ordy;
    #1;
    exp_rdy = !r && !c && !m_done && (m_taken < LEN);
    checkOutput("in_ready", in_ready, exp_rdy);
    checkOutput("out_valid", out_valid, m_done);
    checkOutput("acc_out", acc_out, m_sum % (1 << ACC_W));
    checkOutput("ovf", ovf, m_sum >= (1 << ACC_W));
    acc_now = iv && exp_rdy;
    last_accepted = acc_now;
    if (in_valid && in_ready) dut_accepts++;
    @(posedge clk);
    if (r || c) begin
      modelClear();
    end else begin
      done_before = m_done;
      if (m_pend) begin
        m_sum += m_prod;
        m_added++;
        if (m_added == LEN) m_done = 1'b1;
      end
      if (done_before && ordy) modelClear();
      if (acc_now) begin
        m_pend  = 1'b1;
        m_prod  = int'(ia) * int'(ib);
        m_taken++;
      end else begin
        m_pend = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic sendPair(input logic [5:0] ia, input logic [5:0] ib, input bit ordy);
    for (int t = 0; t < 50; t++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, ia, ib, ordy);
      if (last_accepted) return;
    end
    checkOutput("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitResult(input bit ordy);
    for (int t = 0; t < 100; t++) begin
      if (out_valid === 1'b1) return;
      applyStimulus(1'b0, 1'b0, 1'b0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), ordy);
    end
    checkOutput("result_timeout", out_valid, 32'd1);
  endtask

  task automatic idle(input bit ordy);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), ordy);
  endtask

  initial begin
    int start;
    bit r, c, iv, ordy;
    logic [5:0] ra, rb;

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    modelClear();

    applyStimulus(1'b1, 1'b0, 1'b1, 6'd3, 6'd3, 1'b0);
    idle(1'b0);

    // Narrow accumulator: two maximal products wrap 12 bits and set ovf
    s_in_valid = 1'b1; s_a = 6'd63; s_b = 6'd63;
    #1;
    checkOutput("s_in_ready", s_in_ready, 32'd1);
    idle(1'b0);
    idle(1'b0);
    checkOutput("s_acc_partial", s_acc_out, 32'd3969);
    checkOutput("s_ovf_partial", s_ovf, 32'd0);
    s_in_valid = 1'b0;
    idle(1'b0);
    checkOutput("s_out_valid", s_out_valid, 32'd1);
    checkOutput("s_acc", s_acc_out, 32'd3842);
    checkOutput("s_ovf", s_ovf, 32'd1);
    checkOutput("s_in_ready_done", s_in_ready, 32'd0);
    s_out_ready = 1'b1;
    idle(1'b0);
    s_out_ready = 1'b0;
    checkOutput("s_out_valid_clr", s_out_valid, 32'd0);
    checkOutput("s_acc_clr", s_acc_out, 32'd0);

    start = cyc;
    sendPair(6'd3, 6'd5, 1'b1);
    sendPair(6'd7, 6'd9, 1'b1);
    sendPair(6'd0, 6'd63, 1'b1);
    sendPair(6'd63, 6'd1, 1'b1);
    waitResult(1'b1);
    checkOutput("t1_latency", cyc - start, 32'd5);
    checkOutput("t1_acc", acc_out, 32'd141);
    checkOutput("t1_ovf", ovf, 32'd0);
    idle(1'b1);

    for (int i = 0; i < 4; i++) sendPair(6'd63, 6'd63, 1'b0);
    waitResult(1'b0);
    checkOutput("t2_acc", acc_out, 32'd15876);
    checkOutput("t2_ovf", ovf, 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      checkOutput("bp_acc", acc_out, 32'd15876);
      checkOutput("bp_in_ready", in_ready, 32'd0);
    end
    idle(1'b1);
    checkOutput("bp_out_valid", out_valid, 32'd0);
    checkOutput("bp_in_ready_after", in_ready, 32'd1);
    checkOutput("bp_acc_after", acc_out, 32'd0);

    dut_accepts = 0;
    for (int i = 0; i < 4; i++) begin
      sendPair(6'd2, 6'd2, 1'b0);
      idle(1'b0);
      idle(1'b0);
    end
    waitResult(1'b0);
    checkOutput("gap_acc", acc_out, 32'd16);
    checkOutput("gap_accepts", dut_accepts, 32'd4);
    idle(1'b1);

    // Abort with clr, then with rst, each while a product is still in flight
    for (int k = 0; k < 2; k++) begin
      sendPair(6'd5, 6'd6, 1'b0);
      sendPair(6'd7, 6'd8, 1'b0);
      applyStimulus(k == 1, k == 0, 1'b1, 6'd9, 6'd9, 1'b0);
      checkOutput("abort_acc", acc_out, 32'd0);
      checkOutput("abort_out_valid", out_valid, 32'd0);
      for (int i = 0; i < 4; i++) sendPair(6'd1, 6'd1, 1'b0);
      waitResult(1'b0);
      checkOutput("abort_result", acc_out, 32'd4);
      idle(1'b1);
    end

    for (int i = 0; i < 4; i++) sendPair(6'd5, 6'd5, 1'b1);
    waitResult(1'b1);
    checkOutput("b2b_first", acc_out, 32'd100);
    for (int i = 0; i < 4; i++) sendPair(6'd10, 6'd10, 1'b1);
    waitResult(1'b1);
    checkOutput("b2b_second", acc_out, 32'd400);
    idle(1'b1);

    for (int i = 0; i < 1500; i++) begin
      r    = ($urandom_range(0, 99) == 0);
      c    = ($urandom_range(0, 49) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      ra   = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
      rb   = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
      applyStimulus(r, c, iv, ra, rb, ordy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
